// File: rtl/nor_seq_pkg.sv
// Shared types for the NOR-unit sequencer.
//   nor_op_e        : the four ops built from the single NOR array
//   nor_seq_state_e : sequencer FSM states
//   nor_req_t       : request latched at accept (op + operands)
//   npass()         : number of NOR passes an op needs (1..3)
package nor_seq_pkg;

  typedef enum logic [1:0] {OP_NOR, OP_NOT, OP_OR, OP_AND} nor_op_e;

  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_DONE} nor_seq_state_e;

  typedef struct packed {
    nor_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
  } nor_req_t;

  function automatic logic [1:0] npass(input nor_op_e op);
    case (op)
      OP_OR:   npass = 2'd2;
      OP_AND:  npass = 2'd3;
      default: npass = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/nor_gate_8bit.sv
// Physical 8-bit NOR array shared by all requesters.
//   a, b : operands
//   y    : ~(a | b)
module nor_gate_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = ~(a | b);
endmodule

// File: rtl/nor_unit_sequencer.sv
// Shares one nor_gate_8bit among NUM_REQ requesters. NOR/NOT take one pass,
// OR two, AND three; each pass is one registered cycle through the array.
// Round-robin arbitration in IDLE, one op in flight, valid/ready response.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-requester handshake (ready one-hot or zero)
//   req_op/req_a/req_b    : packed per-requester op and operands
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id, rsp_y         : owner index and result, stable while rsp_valid
//   busy                  : sequencer not in IDLE
module nor_unit_sequencer
  import nor_seq_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*NUM_REQ-1:0]   req_op,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [7:0]             rsp_y,
  output logic                   busy
);

  nor_seq_state_e state, state_nxt;
  nor_req_t       req_q;
  logic [ID_W-1:0] rr_ptr, id_q, grant;
  logic            gnt_vld, accept;
  logic [7:0]      t0, t1, nor_a, nor_b, nor_y;

  // Arbiter: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        grant   = ID_W'(idx);
      end
    end
  end

  assign accept = (state == S_IDLE) && gnt_vld;

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_P0;
      S_P0:    state_nxt = (npass(req_q.op) == 2'd1) ? S_DONE : S_P1;
      S_P1:    state_nxt = (npass(req_q.op) == 2'd2) ? S_DONE : S_P2;
      S_P2:    state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOR input mux. P0: NOT/AND invert a; P1: OR re-inverts t0, AND inverts b;
  // P2: AND combines ~a and ~b.
  always_comb begin
    nor_a = req_q.a;
    nor_b = req_q.b;
    case (state)
      S_P0: if (req_q.op == OP_NOT || req_q.op == OP_AND) nor_b = req_q.a;
      S_P1: begin
        if (req_q.op == OP_OR) begin
          nor_a = t0;
          nor_b = t0;
        end else begin
          nor_a = req_q.b;
          nor_b = req_q.b;
        end
      end
      S_P2: begin
        nor_a = t0;
        nor_b = t1;
      end
      default: ;
    endcase
  end

  nor_gate_8bit u_nor (
    .a (nor_a),
    .b (nor_b),
    .y (nor_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      req_q  <= '0;
      id_q   <= '0;
      t0     <= '0;
      t1     <= '0;
      rsp_y  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          req_q.op <= nor_op_e'(req_op[2*grant +: 2]);
          req_q.a  <= req_a[8*grant +: 8];
          req_q.b  <= req_b[8*grant +: 8];
          id_q     <= grant;
          rr_ptr   <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);
        end
        S_P0: if (npass(req_q.op) == 2'd1) rsp_y <= nor_y; else t0 <= nor_y;
        S_P1: if (npass(req_q.op) == 2'd2) rsp_y <= nor_y; else t1 <= nor_y;
        S_P2: rsp_y <= nor_y;
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == S_DONE);
  assign rsp_id    = id_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_nor_unit_sequencer.sv
// Randomized + directed bench for nor_unit_sequencer against a transaction
// level reference: round-robin grant search, op truth, fixed latencies.
module tb_nor_unit_sequencer;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op = '0;
  logic [8*N-1:0]  req_a = '0;
  logic [8*N-1:0]  req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [7:0]      rsp_y;
  logic            busy;

  nor_unit_sequencer #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int chks = 0;
  int ptr_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int grant_m(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [7:0] ref_y(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return ~(a | b);
      2'd1:    return ~a;
      2'd2:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Cycles from accept to rsp_valid.
  function automatic int lat_m(input logic [1:0] op);
    return (op < 2) ? 2 : (op == 2) ? 3 : 4;
  endfunction

  function automatic logic [8*N-1:0] rnd_bus();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  // Called at a negedge with the DUT idle.
  task automatic do_op(input logic [N-1:0] vm, input logic [2*N-1:0] ops,
                       input logic [8*N-1:0] as, input logic [8*N-1:0] bs,
                       input int hold, input bit scr);
    int g, cyc;
    bit seen;
    logic [1:0] op;
    logic [7:0] ey;
    g = grant_m(vm, ptr_m);
    req_valid = vm; req_op = ops; req_a = as; req_b = bs; rsp_ready = 1'b0;
    #1;
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
    if (g < 0) begin
      @(negedge clk);
      chk("idle_no_accept", 32'(busy), 32'd0);
      return;
    end
    op = ops[2*g +: 2];
    ey = ref_y(op, as[8*g +: 8], bs[8*g +: 8]);
    @(negedge clk);
    req_valid = N'($urandom);
    if (scr) begin
      req_op = (2*N)'($urandom); req_a = rnd_bus(); req_b = rnd_bus();
    end
    #1;
    cyc = 1; seen = 0;
    while (!seen && cyc <= 8) begin
      if (rsp_valid) seen = 1;
      else begin
        chk("inflight_busy_ready", {busy, 27'd0, req_ready}, 32'h8000_0000);
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      do_reset();
      return;
    end
    chk("latency", 32'(cyc), 32'(lat_m(op)));
    chk("rsp_y", 32'(rsp_y), 32'(ey));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    req_valid = '1;
    #1;
    chk("done_ready", 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_state", {rsp_valid, busy, 26'd0, req_ready}, 32'hC000_0000);
      chk("hold_y", 32'(rsp_y), 32'(ey));
      chk("hold_id", 32'(rsp_id), 32'(g));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_handshake", {31'd0, rsp_valid | busy}, 32'd0);
    ptr_m = (g + 1) % N;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed ops: NOR req0, NOT req1 with operand scramble, AND req2, OR req3 with backpressure.
    do_op(4'b0001, 8'b0000_0000, 32'h0000_00F0, 32'h0000_000C, 0, 0);
    do_op(4'b0010, 8'b0000_0100, 32'h0000_5A00, 32'h0000_0000, 0, 1);
    do_op(4'b0100, 8'b0011_0000, 32'h00CA_0000, 32'h006F_0000, 0, 1);
    do_op(4'b1000, 8'b1000_0000, 32'hA000_0000, 32'h0500_0000, 5, 0);

    // Round robin: all valid, then only req1/req3.
    for (int i = 0; i < 5; i++) do_op(4'b1111, 8'($urandom), rnd_bus(), rnd_bus(), 0, 0);
    for (int i = 0; i < 3; i++) do_op(4'b1010, 8'($urandom), rnd_bus(), rnd_bus(), 0, 0);

    // Reset during P1 of an AND on req2 (pointer would otherwise favour req3).
    do_op(4'b0010, 8'h00, rnd_bus(), rnd_bus(), 0, 0);
    req_valid = 4'b0100; req_op = 8'b0011_0000; req_a = rnd_bus(); req_b = rnd_bus();
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midop_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    do_op(4'b1001, 8'($urandom), rnd_bus(), rnd_bus(), 0, 0);

    // Random traffic.
    for (int i = 0; i < 150; i++)
      do_op(N'($urandom), 8'($urandom), rnd_bus(), rnd_bus(),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
